booth_product_collector: RTL and testbench

- Downstream stage of the 5-bit Booth multiplier datapath. Consumes the two serialized result words that the datapath drives on its data_out during readout: low word (X register) first, then high word (A register).
- Reassembles each pair into a 10-bit two's-complement product and buffers products in a small first-word-fall-through FIFO.
- Presents products to the consumer with a valid/ready handshake.
- Back-pressures the multiplier controller via a full flag.

---
 rtl/booth_pkg.sv | 22 ++
 rtl/booth_prod_fifo.sv | 91 +++++++++
 rtl/booth_product_collector.sv | 176 +++++++++++++++++
 tb/tb_booth_product_collector.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared constants and types for the Booth multiplier readout
// path. It provides the default datapath word width, the product width, the
// product collector state encoding and a signed product type.
package booth_pkg;

    // Width of one datapath output word (A or X register).
    localparam int WORD_W = 5;

    // A product is the {A, X} register pair.
    localparam int PROD_W = 2 * WORD_W;

    // Pair-assembly state. In WAIT_LO the collector expects the X (low)
    // word. In WAIT_HI it holds a low word and expects the A (high) word.
    typedef enum logic [0:0] {
        WAIT_LO = 1'b0,
        WAIT_HI = 1'b1
    } coll_state_e;

    // Two's-complement product of the default-width datapath.
    typedef logic signed [PROD_W-1:0] prod_t;

endpackage

// File: rtl/booth_prod_fifo.sv
// booth_prod_fifo: first-word-fall-through FIFO for assembled products.
// The head entry is always visible on head_data.
//
// Ports
//   clk, rst   : rising-edge clock and synchronous active-low reset
//   push_req   : request to write push_data
//   push_data  : entry to write
//   pop_req    : request to drop the head entry; ignored when empty
//   full       : count == DEPTH
//   empty      : count == 0
//   count      : current occupancy
//   head_data  : oldest entry, read combinationally from storage
//   push_acc   : push_req was accepted this cycle
//
// When the FIFO is full, a push that coincides with a pop is still accepted,
// because the pop frees the slot on the same edge.
module booth_prod_fifo #(
    parameter int DATA_W = booth_pkg::PROD_W,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_req,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_req,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] head_data,
    output logic              push_acc
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              pop_acc_s;
    logic              push_acc_s;
    logic              full_s;
    logic              empty_s;

    // Accept/reject decisions for this cycle's push and pop.
    always_comb begin
        full_s     = (count_r == CNT_W'(DEPTH));
        empty_s    = (count_r == {CNT_W{1'b0}});
        pop_acc_s  = pop_req & ~empty_s;
        push_acc_s = push_req & (~full_s | pop_acc_s);
    end

    // Storage and pointers. The pointers wrap naturally because DEPTH is a
    // power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_acc_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Occupancy counter. It is unchanged when a push and a pop coincide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({push_acc_s, pop_acc_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign full      = full_s;
    assign empty     = empty_s;
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];
    assign push_acc  = push_acc_s;

endmodule

// File: rtl/booth_product_collector.sv
// booth_product_collector: reassembles the serialized X (low) and A (high)
// result words of the Booth multiplier into 10-bit signed products. It
// buffers the products in a FWFT FIFO and hands them out with valid/ready.
//
// Ports
//   clk, rst   : rising-edge clock and synchronous active-low reset
//   word_in    : datapath data_out
//   word_vld   : word_in is valid this cycle
//   word_hi    : 1 = high (A) word, 0 = low (X) word
//   full       : FIFO full; the controller must hold off readout
//   prod_data  : head product {hi, lo}
//   prod_valid : FIFO not empty
//   prod_ready : consumer accepts the head product
//   count      : FIFO occupancy
//   seq_err    : sticky, set when the word order is violated
//   ovf_err    : sticky, set when a push is attempted while full
//
// Optional build macro BOOTH_COLLECTOR_ACC_EN adds:
//   acc_clr    : zero the accumulator; takes priority over an add
//   acc_out    : running signed sum of accepted products, modulo 2^ACC_W
module booth_product_collector
    import booth_pkg::*;
#(
    parameter int WORD_W     = booth_pkg::WORD_W,
    parameter int FIFO_DEPTH = 4
`ifdef BOOTH_COLLECTOR_ACC_EN
    ,
    parameter int ACC_W      = 16
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WORD_W-1:0]             word_in,
    input  logic                          word_vld,
    input  logic                          word_hi,
    output logic                          full,
    output logic [2*WORD_W-1:0]           prod_data,
    output logic                          prod_valid,
    input  logic                          prod_ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          seq_err,
    output logic                          ovf_err
`ifdef BOOTH_COLLECTOR_ACC_EN
    ,
    input  logic                          acc_clr,
    output logic signed [ACC_W-1:0]       acc_out
`endif
);

    localparam int PRD_W = 2 * WORD_W;

    coll_state_e       state_r;
    coll_state_e       state_nxt_s;
    logic [WORD_W-1:0] lo_r;
    logic [WORD_W-1:0] lo_nxt_s;
    logic              push_req_s;
    logic              push_acc_s;
    logic              seq_set_s;
    logic              ovf_set_s;
    logic              empty_s;
    logic [PRD_W-1:0]  push_data_s;
    logic              seq_err_r;
    logic              ovf_err_r;

    // Pair-assembly next state. A word that arrives out of order is either
    // dropped (high word while waiting for low) or replaces the held low
    // word (low word while waiting for high). Both cases flag seq_err.
    always_comb begin
        state_nxt_s = state_r;
        lo_nxt_s    = lo_r;
        push_req_s  = 1'b0;
        seq_set_s   = 1'b0;
        case (state_r)
            WAIT_LO: begin
                if (word_vld) begin
                    if (word_hi) begin
                        seq_set_s = 1'b1;
                    end else begin
                        lo_nxt_s    = word_in;
                        state_nxt_s = WAIT_HI;
                    end
                end else begin
                    state_nxt_s = WAIT_LO;
                end
            end
            WAIT_HI: begin
                if (word_vld) begin
                    if (word_hi) begin
                        push_req_s  = 1'b1;
                        state_nxt_s = WAIT_LO;
                    end else begin
                        lo_nxt_s  = word_in;
                        seq_set_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = WAIT_HI;
                end
            end
            default: begin
                state_nxt_s = WAIT_LO;
            end
        endcase
    end

    // A push that the FIFO refuses is an overflow.
    always_comb begin
        push_data_s = {word_in, lo_r};
        ovf_set_s   = push_req_s & ~push_acc_s;
    end

    // FSM state and the held low word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= WAIT_LO;
            lo_r    <= {WORD_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            lo_r    <= lo_nxt_s;
        end
    end

    // Sticky error flags. Only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seq_err_r <= 1'b0;
            ovf_err_r <= 1'b0;
        end else begin
            seq_err_r <= seq_err_r | seq_set_s;
            ovf_err_r <= ovf_err_r | ovf_set_s;
        end
    end

    booth_prod_fifo #(
        .DATA_W (PRD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_req  (push_req_s),
        .push_data (push_data_s),
        .pop_req   (prod_ready),
        .full      (full),
        .empty     (empty_s),
        .count     (count),
        .head_data (prod_data),
        .push_acc  (push_acc_s)
    );

    assign prod_valid = ~empty_s;
    assign seq_err    = seq_err_r;
    assign ovf_err    = ovf_err_r;

`ifdef BOOTH_COLLECTOR_ACC_EN
    logic signed [PRD_W-1:0] prod_signed_s;
    logic signed [ACC_W-1:0] acc_r;

    assign prod_signed_s = signed'(push_data_s);

    // Running sum of accepted products. The product is sign-extended to
    // ACC_W, and the sum wraps modulo 2^ACC_W.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (acc_clr) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (push_acc_s) begin
            acc_r <= acc_r + ACC_W'(prod_signed_s);
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc_out = acc_r;
`endif

endmodule

// File: tb/tb_booth_product_collector.sv
// tb_booth_product_collector: table-driven directed test of the product
// collector. Each table row holds one cycle's inputs and the outputs expected
// after that clock edge. Hand-written sequences cover reset in the middle of
// a pair and, when the accumulator is built in, the accumulator.
module tb_booth_product_collector;

    logic       clk;
    logic       rst;
    logic [4:0] word_in;
    logic       word_vld;
    logic       word_hi;
    logic       full;
    logic [9:0] prod_data;
    logic       prod_valid;
    logic       prod_ready;
    logic [2:0] count;
    logic       seq_err;
    logic       ovf_err;
`ifdef BOOTH_COLLECTOR_ACC_EN
    logic        acc_clr;
    logic [15:0] acc_out;
`endif

    int n_cmp;
    int n_bad;

    booth_product_collector dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_vld   (word_vld),
        .word_hi    (word_hi),
        .full       (full),
        .prod_data  (prod_data),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .count      (count),
        .seq_err    (seq_err),
        .ovf_err    (ovf_err)
`ifdef BOOTH_COLLECTOR_ACC_EN
        ,
        .acc_clr    (acc_clr),
        .acc_out    (acc_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       v;
        logic       h;
        logic [4:0] w;
        logic       rd;
        logic       ev;
        logic [9:0] ed;
        logic [2:0] ec;
        logic       es;
        logic       eo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic v, input logic h,
                                input logic [4:0] w, input logic rd,
                                input logic ev, input logic [9:0] ed,
                                input logic [2:0] ec, input logic es,
                                input logic eo);
        vec_t t;
        t.r = r;   t.v = v;   t.h = h;   t.w = w;   t.rd = rd;
        t.ev = ev; t.ed = ed; t.ec = ec; t.es = es; t.eo = eo;
        return t;
    endfunction

    // Four pairs with distinct products 0x022, 0x3FE, 0x200 and 0x1FF.
    // The head stays 0x022 throughout.
    task automatic add_fill(input logic eo);
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 5'h02, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, eo));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 5'h01, 1'b0, 1'b1, 10'h022, 3'd1, 1'b0, eo));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 5'h1E, 1'b0, 1'b1, 10'h022, 3'd1, 1'b0, eo));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 5'h1F, 1'b0, 1'b1, 10'h022, 3'd2, 1'b0, eo));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 5'h00, 1'b0, 1'b1, 10'h022, 3'd2, 1'b0, eo));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 5'h10, 1'b0, 1'b1, 10'h022, 3'd3, 1'b0, eo));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 5'h1F, 1'b0, 1'b1, 10'h022, 3'd3, 1'b0, eo));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 5'h0F, 1'b0, 1'b1, 10'h022, 3'd4, 1'b0, eo));
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic h,
                         input logic [4:0] w, input logic rd);
        rst        = r;
        word_vld   = v;
        word_hi    = h;
        word_in    = w;
        prod_ready = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [9:0] ed,
                           input logic [2:0] ec, input logic es, input logic eo);
        chk({tag, " prod_valid"}, {31'd0, prod_valid}, {31'd0, ev});
        if (ev) begin
            chk({tag, " prod_data"}, {22'd0, prod_data}, {22'd0, ed});
        end
        chk({tag, " count"},   {29'd0, count},   {29'd0, ec});
        chk({tag, " full"},    {31'd0, full},    {31'd0, (ec == 3'd4)});
        chk({tag, " seq_err"}, {31'd0, seq_err}, {31'd0, es});
        chk({tag, " ovf_err"}, {31'd0, ovf_err}, {31'd0, eo});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        drive(1'b0, 1'b0, 1'b0, 5'h00, 1'b0);
`ifdef BOOTH_COLLECTOR_ACC_EN
        acc_clr = 1'b0;
`endif

        // Reset state.
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 1'b0));
        // Single product: 7 * -3 = -21 = 0x3EB, then pop it.
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 5'h0B, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 5'h1F, 1'b0, 1'b1, 10'h3EB, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 10'h000, 3'd0, 1'b0, 1'b0));
        // Fill to 4, then a fifth pair (0x0A5) overflows and is dropped.
        add_fill(1'b0);
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 5'h05, 1'b0, 1'b1, 10'h022, 3'd4, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 5'h05, 1'b0, 1'b1, 10'h022, 3'd4, 1'b0, 1'b1));
        // Drain in order.
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 10'h3FE, 3'd3, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 10'h200, 3'd2, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 10'h1FF, 3'd1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 10'h000, 3'd0, 1'b0, 1'b1));
        // Reset clears ovf_err. Refill, then push and pop on the same edge while full.
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 1'b0));
        add_fill(1'b0);
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 5'h15, 1'b0, 1'b1, 10'h022, 3'd4, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 5'h00, 1'b1, 1'b1, 10'h3FE, 3'd4, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 10'h200, 3'd3, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 10'h1FF, 3'd2, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 10'h015, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 10'h000, 3'd0, 1'b0, 1'b0));
        // Sequence errors: a high word in WAIT_LO is dropped; of lo, lo, hi the second lo wins.
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 5'h07, 1'b0, 1'b0, 10'h000, 3'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 5'h01, 1'b0, 1'b0, 10'h000, 3'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 5'h02, 1'b0, 1'b0, 10'h000, 3'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 5'h00, 1'b0, 1'b1, 10'h002, 3'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 10'h000, 3'd0, 1'b1, 1'b0));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].h, tbl[i].w, tbl[i].rd);
            tick();
            chk_all($sformatf("step%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec,
                    tbl[i].es, tbl[i].eo);
        end

        // Reset in the middle of a pair discards the held low word.
        drive(1'b0, 1'b0, 1'b0, 5'h00, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'h0F, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'h00, 1'b0);
        tick();
        chk_all("midrst reset", 1'b0, 10'h000, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 5'h00, 1'b0);
        tick();
        chk_all("midrst hi", 1'b0, 10'h000, 3'd0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 5'h00, 1'b0);
        tick();
        chk_all("midrst idle", 1'b0, 10'h000, 3'd0, 1'b1, 1'b0);

`ifdef BOOTH_COLLECTOR_ACC_EN
        // Accumulator: -21, then +21 gives 0, clr beats an add, then +5.
        drive(1'b0, 1'b0, 1'b0, 5'h00, 1'b0);
        tick();
        chk("acc reset", {16'd0, acc_out}, 32'h0000_0000);
        drive(1'b1, 1'b1, 1'b0, 5'h0B, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 5'h1F, 1'b0);
        tick();
        chk("acc -21", {16'd0, acc_out}, 32'h0000_FFEB);
        drive(1'b1, 1'b1, 1'b0, 5'h15, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 5'h00, 1'b0);
        tick();
        chk("acc 0", {16'd0, acc_out}, 32'h0000_0000);
        drive(1'b1, 1'b1, 1'b0, 5'h05, 1'b0);
        tick();
        acc_clr = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'h00, 1'b0);
        tick();
        acc_clr = 1'b0;
        chk("acc clr", {16'd0, acc_out}, 32'h0000_0000);
        chk("acc clr count", {29'd0, count}, 32'd3);
        drive(1'b1, 1'b1, 1'b0, 5'h05, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 5'h00, 1'b0);
        tick();
        chk("acc +5", {16'd0, acc_out}, 32'h0000_0005);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
